// File: rtl/tx_engine.sv
// UART transmit engine: serialises an 11-bit frame (mark, start, data[6:0], d9, d10) LSB first.
// Optional break generation is enabled by defining TX_BREAK_EN.
module tx_engine #(
    parameter int unsigned BAUD_W = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [BAUD_W-1:0] k,
    input  logic              load,
    input  logic [7:0]        data,
    input  logic              d10,
    input  logic              d9,
`ifdef TX_BREAK_EN
    input  logic              brk,
`endif
    output logic              tx,
    output logic              tx_rdy
);

    localparam int unsigned FRAME_W = 11;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

`ifdef TX_BREAK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, BREAK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t               state;
    logic [FRAME_W-1:0]   sr;
    logic [BAUD_W-1:0]    k_q;
    logic [BAUD_W-1:0]    bt_cnt;
    logic [CNT_W-1:0]     bit_cnt;

    // data[7] reaches the line only through d9, as decided by the upstream decoder
    logic unused_data7;
    assign unused_data7 = data[7];

    // Frame sequencer; tx is loaded with the bit that sr[0] will hold after the edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sr      <= '1;
            k_q     <= '0;
            bt_cnt  <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            tx_rdy  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx     <= 1'b1;
                    tx_rdy <= 1'b1;
`ifdef TX_BREAK_EN
                    if (brk) begin
                        state  <= BREAK;
                        tx     <= 1'b0;
                        tx_rdy <= 1'b0;
                    end else
`endif
                    if (load) begin
                        sr      <= {d10, d9, data[6:0], 1'b0, 1'b1};
                        k_q     <= k;
                        bt_cnt  <= '0;
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                        tx_rdy  <= 1'b0;
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (bt_cnt == k_q) begin
                        bt_cnt <= '0;
                        sr     <= {1'b1, sr[FRAME_W-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            // eleventh bit time elapsed: frame done
                            bit_cnt <= '0;
                            state   <= IDLE;
                            tx      <= 1'b1;
                            tx_rdy  <= 1'b1;
`ifdef TX_BREAK_EN
                            if (brk) begin
                                state  <= BREAK;
                                tx     <= 1'b0;
                                tx_rdy <= 1'b0;
                            end
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            tx      <= sr[1];
                        end
                    end else begin
                        bt_cnt <= bt_cnt + BAUD_W'(1);
                    end
                end

`ifdef TX_BREAK_EN
                BREAK: begin
                    if (brk) begin
                        tx     <= 1'b0;
                        tx_rdy <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        tx     <= 1'b1;
                        tx_rdy <= 1'b1;
                    end
                end
`endif

                default: begin
                    state  <= IDLE;
                    tx     <= 1'b1;
                    tx_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_engine.sv
// Bench for tx_engine: directed frame table, hand-written corner sequences and randomized frames
// checked against a frame model built from the line-format rules.
module tb_tx_engine;

    localparam int unsigned BAUD_W = 19;

    logic              clk;
    logic              reset_n;
    logic [BAUD_W-1:0] k;
    logic              load;
    logic [7:0]        data;
    logic              d10;
    logic              d9;
    logic              tx;
    logic              tx_rdy;
`ifdef TX_BREAK_EN
    logic              brk;
`endif

    int checks = 0;
    int errors = 0;

    tx_engine #(.BAUD_W(BAUD_W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .k      (k),
        .load   (load),
        .data   (data),
        .d10    (d10),
        .d9     (d9),
`ifdef TX_BREAK_EN
        .brk    (brk),
`endif
        .tx     (tx),
        .tx_rdy (tx_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kk;
        logic [7:0] data;
        logic       d10;
        logic       d9;
        logic [10:0] frame;
        int         busy;
        int         mode;
    } vec_t;

    task automatic check(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d actual=%0h expected=%0h", name, n, act, exp);
        end
    endtask

    // Line bit j of the frame: mark, start, seven data bits, then d9 and d10
    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic p10, input logic p9);
        logic [10:0] f;
        f[0] = 1'b1;
        f[1] = 1'b0;
        for (int i = 0; i < 7; i++) f[2+i] = d[i];
        f[9]  = p9;
        f[10] = p10;
        return f;
    endfunction

    // Caller has set inputs with load=1 at a negedge; n counts edges after the load edge.
    // mode: 0 quiet, 1 late load + k change, 2 random noise on inputs, 3 break request mid-frame
    task automatic run_frame(input int kk, input logic [10:0] f, input int busy, input int mode,
                             input logic end_brk);
        int low;
        low = 0;
        @(posedge clk);
        for (int n = 0; n <= busy; n++) begin
            if (n > 0) @(negedge clk);
            else @(negedge clk);
            if (n < busy) begin
                check("tx", n, 32'(tx), 32'(f[n/(kk+1)]));
                check("tx_rdy_busy", n, 32'(tx_rdy), 32'(0));
                if (!tx_rdy) low++;
            end else begin
                check("tx_end", n, 32'(tx), end_brk ? 32'(0) : 32'(1));
                check("tx_rdy_end", n, 32'(tx_rdy), end_brk ? 32'(0) : 32'(1));
            end
            if (n == 0) load = 1'b0;
            if (mode == 1) begin
                if (n == 10) begin load = 1'b1; data = 8'hFF; end
                if (n == 11) load = 1'b0;
                if (n == 12) k = BAUD_W'(7);
            end
            if (mode == 2 && n < busy) begin
                load = 1'($urandom);
                data = 8'($urandom);
                d10  = 1'($urandom);
                d9   = 1'($urandom);
                k    = BAUD_W'($urandom_range(0, 7));
            end
`ifdef TX_BREAK_EN
            if (mode == 3 && n == 5) brk = 1'b1;
`endif
            if (n == busy) load = 1'b0;
        end
        check("busy_len", busy, 32'(low), 32'(busy));
    endtask

    task automatic set_inputs(input int kk, input logic [7:0] d, input logic p10, input logic p9);
        k    = BAUD_W'(kk);
        data = d;
        d10  = p10;
        d9   = p9;
        load = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[3];
        logic [10:0] f2;
        int kk;
        logic [7:0] d;
        logic p10, p9;

        vecs[0] = '{kk: 3, data: 8'h55, d10: 1'b1, d9: 1'b0, frame: 11'h555, busy: 44, mode: 0};
        vecs[1] = '{kk: 0, data: 8'h0F, d10: 1'b1, d9: 1'b1, frame: 11'h63D, busy: 11, mode: 0};
        vecs[2] = '{kk: 2, data: 8'hA5, d10: 1'b0, d9: 1'b1, frame: 11'h295, busy: 33, mode: 1};

        clk = 1'b0;
        reset_n = 1'b0;
        k = '0; load = 1'b0; data = '0; d10 = 1'b0; d9 = 1'b0;
`ifdef TX_BREAK_EN
        brk = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_tx", 0, 32'(tx), 32'(1));
        check("reset_rdy", 0, 32'(tx_rdy), 32'(1));
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_tx", 0, 32'(tx), 32'(1));
            check("idle_rdy", 0, 32'(tx_rdy), 32'(1));
        end

        // Directed frames from the table
        for (int i = 0; i < 3; i++) begin
            set_inputs(vecs[i].kk, vecs[i].data, vecs[i].d10, vecs[i].d9);
            run_frame(vecs[i].kk, vecs[i].frame, vecs[i].busy, vecs[i].mode, 1'b0);
            @(negedge clk);
            check("post_idle_tx", i, 32'(tx), 32'(1));
            check("post_idle_rdy", i, 32'(tx_rdy), 32'(1));
        end

        // Back-to-back: second load in the cycle tx_rdy returns
        set_inputs(1, 8'h3C, 1'b0, 1'b1);
        run_frame(1, model_frame(8'h3C, 1'b0, 1'b1), 22, 0, 1'b0);
        set_inputs(1, 8'hC3, 1'b1, 1'b0);
        run_frame(1, model_frame(8'hC3, 1'b1, 1'b0), 22, 0, 1'b0);

        // Asynchronous reset in the middle of bit 5 (data[3]=0 -> tx low)
        set_inputs(3, 8'h55, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        repeat (20) @(negedge clk);
        check("bit5_low", 20, 32'(tx), 32'(0));
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_tx", 0, 32'(tx), 32'(1));
        check("async_rst_rdy", 0, 32'(tx_rdy), 32'(1));
        @(negedge clk);
        check("rst_hold_tx", 0, 32'(tx), 32'(1));
        reset_n = 1'b1;
        @(negedge clk);
        set_inputs(2, 8'h4B, 1'b1, 1'b0);
        run_frame(2, model_frame(8'h4B, 1'b1, 1'b0), 33, 0, 1'b0);

`ifdef TX_BREAK_EN
        // Break in idle wins over a simultaneous load
        set_inputs(1, 8'h12, 1'b0, 1'b0);
        brk = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("brk_tx", c, 32'(tx), 32'(0));
            check("brk_rdy", c, 32'(tx_rdy), 32'(0));
        end
        brk = 1'b0;
        load = 1'b0;
        @(negedge clk);
        check("brk_exit_tx", 0, 32'(tx), 32'(1));
        check("brk_exit_rdy", 0, 32'(tx_rdy), 32'(1));
        // Break requested mid-frame is held off until the frame ends
        set_inputs(1, 8'h69, 1'b1, 1'b1);
        run_frame(1, model_frame(8'h69, 1'b1, 1'b1), 22, 3, 1'b1);
        brk = 1'b0;
        @(negedge clk);
        check("brk2_exit_tx", 0, 32'(tx), 32'(1));
        check("brk2_exit_rdy", 0, 32'(tx_rdy), 32'(1));
`endif

        // Randomized frames with noisy inputs during transmission
        for (int i = 0; i < 20; i++) begin
            int gap;
            kk  = $urandom_range(0, 5);
            d   = 8'($urandom);
            p10 = 1'($urandom);
            p9  = 1'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("rand_idle_tx", g, 32'(tx), 32'(1));
                check("rand_idle_rdy", g, 32'(tx_rdy), 32'(1));
            end
            f2 = model_frame(d, p10, p9);
            set_inputs(kk, d, p10, p9);
            run_frame(kk, f2, 11 * (kk + 1), 2, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
